// File: rtl/bn_quant_if.sv
// bn_quant_if: element stream, coefficient port and MVM handshake of the batch-norm/quantise stage
interface bn_quant_if #(
    parameter int ACC_W = 12,
    parameter int G_W   = 8
);
    logic                    i_valid_bn;
    logic signed [ACC_W-1:0] i_data_bn;
    logic                    o_ready_bn;
    logic                    i_cfg_we;
    logic [1:0]              i_cfg_lane;
    logic signed [G_W-1:0]   i_cfg_gamma;
    logic signed [ACC_W-1:0] i_cfg_beta;
    logic                    i_ismvm;
    logic                    o_start_mvm;
    logic [3:0][3:0]         o_x_bn;
    logic [15:0]             o_vec_cnt;
    logic                    o_err_bn;
    modport slave (
        input  i_valid_bn, i_data_bn, i_cfg_we, i_cfg_lane, i_cfg_gamma, i_cfg_beta, i_ismvm,
        output o_ready_bn, o_start_mvm, o_x_bn, o_vec_cnt, o_err_bn
    );
    modport master (
        output i_valid_bn, i_data_bn, i_cfg_we, i_cfg_lane, i_cfg_gamma, i_cfg_beta, i_ismvm,
        input  o_ready_bn, o_start_mvm, o_x_bn, o_vec_cnt, o_err_bn
    );
endinterface

// File: rtl/bn_quant.sv
// bn_quant: per-lane gamma/beta transform with 4-bit clamp, packs four results and hands them to the MVM
module bn_quant #(
    parameter int ACC_W    = 12,
    parameter int G_W      = 8,
    parameter int FRAC     = 4,
    parameter int LANES    = 4,
    parameter int START_TO = 8
) (
    input logic       i_clk_bn,
    input logic       i_rst_bn,
    bn_quant_if.slave bus
);
    localparam int PW = ACC_W + G_W;
    localparam int TW = $clog2(START_TO + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;
    state_t                  state, nxt;
    logic signed [G_W-1:0]   gamma [LANES];
    logic signed [ACC_W-1:0] beta  [LANES];
    logic [LANES-1:0][3:0]   col, xv;
    logic [1:0]              lane;
    logic                    full, acc, xfer, tout, err;
    logic [TW-1:0]           tcnt;
    logic [15:0]             cnt;
    logic signed [PW-1:0]    p;
    logic signed [PW:0]      s;
    logic [3:0]              q;

    assign acc             = bus.i_valid_bn && !full;
    assign xfer            = state == IDLE && full;
    assign bus.o_ready_bn  = !full;
    assign bus.o_start_mvm = state == ISSUE;
    assign bus.o_x_bn      = xv;
    assign bus.o_vec_cnt   = cnt;
    assign bus.o_err_bn    = err;

    // scale and offset the element with the coefficients of the lane it will fill, then clamp to 0..15
    always_comb begin
        p = PW'(bus.i_data_bn) * PW'(gamma[lane]);
        s = (PW+1)'(p >>> FRAC) + (PW+1)'(beta[lane]);
        q = s[PW] ? 4'd0 : |s[PW-1:4] ? 4'd15 : s[3:0];
    end

    // coefficient table; a write lands at the edge, so an element accepted alongside it sees the old value
    always_ff @(posedge i_clk_bn or negedge i_rst_bn)
        if (!i_rst_bn) begin
            for (int i = 0; i < LANES; i++) begin
                gamma[i] <= G_W'(1 << FRAC);
                beta[i]  <= '0;
            end
        end else if (bus.i_cfg_we) begin
            gamma[bus.i_cfg_lane] <= bus.i_cfg_gamma;
            beta[bus.i_cfg_lane]  <= bus.i_cfg_beta;
        end

    // fill the collect buffer lane by lane; the fourth result marks it full until the FSM takes it
    always_ff @(posedge i_clk_bn or negedge i_rst_bn)
        if (!i_rst_bn) begin
            col  <= '0;
            lane <= '0;
            full <= 1'b0;
        end else begin
            if (acc) begin
                col[lane] <= q;
                lane      <= lane + 2'd1;
            end
            full <= acc && lane == 2'd3 ? 1'b1 : xfer ? 1'b0 : full;
        end

    // FSM state and the registers it owns: held vector, vector count, start timeout and sticky error
    always_ff @(posedge i_clk_bn or negedge i_rst_bn)
        if (!i_rst_bn) begin
            state <= IDLE;
            xv    <= '0;
            cnt   <= '0;
            tcnt  <= '0;
            err   <= 1'b0;
        end else begin
            state <= nxt;
            if (xfer) xv <= col;
            if (state == ISSUE) cnt <= cnt + 16'd1;
            tcnt <= state == WAIT_HI ? tcnt + TW'(1) : '0;
            if (tout) err <= 1'b1;
        end

    // next state; busy is only looked at from WAIT_HI on, and only the rise is time-limited
    always_comb begin
        nxt  = state;
        tout = 1'b0;
        case (state)
            IDLE:    nxt = full ? ISSUE : IDLE;
            ISSUE:   nxt = WAIT_HI;
            WAIT_HI: begin
                tout = !bus.i_ismvm && tcnt == TW'(START_TO - 1);
                nxt  = bus.i_ismvm ? WAIT_LO : tout ? IDLE : WAIT_HI;
            end
            WAIT_LO: nxt = bus.i_ismvm ? WAIT_LO : IDLE;
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bn_quant.sv
// tb_bn_quant: directed and randomized checks of bn_quant against an arithmetic reference model
module tb_bn_quant;
    localparam int FRAC     = 4;
    localparam int START_TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int          mg [4];
    int          mb [4];
    int          part [$];
    logic [15:0] expq [$];
    logic [15:0] last_exp = '0;
    logic [15:0] cnt_exp  = '0;
    int          ph = 0, rw = 0, rb = 0, hi_dly = 1, busy_len = 2;

    bn_quant_if #(.ACC_W(12), .G_W(8)) bus ();

    bn_quant #(.ACC_W(12), .G_W(8), .FRAC(FRAC), .LANES(4), .START_TO(START_TO)) dut (
        .i_clk_bn(clk),
        .i_rst_bn(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_q(input int x, input int g, input int b);
        int p, f, s;
        p = x * g;
        f = p >= 0 ? p / (1 << FRAC) : -((-p + (1 << FRAC) - 1) / (1 << FRAC));
        s = f + b;
        return s < 0 ? 4'd0 : s > 15 ? 4'd15 : 4'(s);
    endfunction

    task automatic model_accept(input int x);
        part.push_back(int'(ref_q(x, mg[part.size()], mb[part.size()])));
        if (part.size() == 4) begin
            expq.push_back(16'(part[0] + part[1] * 16 + part[2] * 256 + part[3] * 4096));
            part.delete();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("cnt", 32'(bus.o_vec_cnt), 32'(cnt_exp));
        if (bus.o_start_mvm) begin
            chk("start_busy", 32'(bus.i_ismvm), 0);
            if (expq.size() == 0) chk("stray_start", 32'(bus.o_start_mvm), 0);
            else begin
                last_exp = expq.pop_front();
                chk("vec", 32'(bus.o_x_bn), 32'(last_exp));
            end
            cnt_exp = cnt_exp + 16'd1;
            if (busy_len > 0) begin
                ph = 1;
                rw = hi_dly;
                rb = busy_len;
            end
        end else chk("hold", 32'(bus.o_x_bn), 32'(last_exp));
        if (ph == 2) begin
            rb--;
            if (rb == 0) begin
                bus.i_ismvm = 1'b0;
                ph = 0;
            end
        end else if (ph == 1) begin
            if (rw == 0) begin
                bus.i_ismvm = 1'b1;
                ph = 2;
            end else rw--;
        end
    endtask

    task automatic send(input int x);
        int n = 0;
        bus.i_valid_bn = 1'b1;
        bus.i_data_bn  = 12'(x);
        while (!bus.o_ready_bn && n < 200) begin
            tick();
            n++;
        end
        if (!bus.o_ready_bn) chk("ready_timeout", 32'(bus.o_ready_bn), 1);
        else model_accept(x);
        tick();
        bus.i_valid_bn = 1'b0;
    endtask

    task automatic cfg(input int l, input int g, input int b);
        bus.i_cfg_we    = 1'b1;
        bus.i_cfg_lane  = 2'(l);
        bus.i_cfg_gamma = 8'(g);
        bus.i_cfg_beta  = 12'(b);
        tick();
        bus.i_cfg_we = 1'b0;
        mg[l] = g;
        mb[l] = b;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || ph != 0) && n < 500) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk("drain", 32'(expq.size()), 0);
    endtask

    task automatic do_reset();
        #1;
        rst_n          = 1'b0;
        bus.i_valid_bn = 1'b0;
        bus.i_cfg_we   = 1'b0;
        bus.i_ismvm    = 1'b0;
        ph             = 0;
        part.delete();
        expq.delete();
        last_exp = '0;
        cnt_exp  = '0;
        for (int i = 0; i < 4; i++) begin
            mg[i] = 1 << FRAC;
            mb[i] = 0;
        end
        #1;
        chk("rst_start", 32'(bus.o_start_mvm), 0);
        chk("rst_ready", 32'(bus.o_ready_bn), 1);
        chk("rst_x", 32'(bus.o_x_bn), 0);
        chk("rst_cnt", 32'(bus.o_vec_cnt), 0);
        chk("rst_err", 32'(bus.o_err_bn), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int x, l, g, b, n;
        bus.i_valid_bn  = 1'b0;
        bus.i_data_bn   = '0;
        bus.i_cfg_we    = 1'b0;
        bus.i_cfg_lane  = '0;
        bus.i_cfg_gamma = '0;
        bus.i_cfg_beta  = '0;
        bus.i_ismvm     = 1'b0;
        do_reset();

        for (int i = 0; i < 4; i++) send(15);
        chk("t1_pre", 32'(bus.o_start_mvm), 0);
        tick();
        chk("t1_start", 32'(bus.o_start_mvm), 1);
        chk("t1_x", 32'(bus.o_x_bn), 32'h0000_FFFF);
        tick();
        chk("t1_post", 32'(bus.o_start_mvm), 0);
        drain();
        chk("t1_cnt", 32'(bus.o_vec_cnt), 1);

        send(-3);
        send(100);
        send(0);
        send(7);
        drain();
        chk("t2_x", 32'(bus.o_x_bn), 32'h0000_70F0);

        cfg(0, 24, 0);
        cfg(1, -32, 0);
        cfg(2, 24, 10);
        cfg(3, 16, -20);
        send(5);
        send(-4);
        send(-5);
        send(3);
        drain();
        chk("t3_x", 32'(bus.o_x_bn), 32'h0000_0287);

        bus.i_cfg_we    = 1'b1;
        bus.i_cfg_lane  = 2'd0;
        bus.i_cfg_gamma = 8'd48;
        bus.i_cfg_beta  = 12'd0;
        send(2);
        bus.i_cfg_we = 1'b0;
        mg[0] = 48;
        mb[0] = 0;
        send(-1);
        cfg(2, 16, 5);
        send(4);
        send(3);
        drain();
        chk("t4_old_coef", 32'(bus.o_x_bn), 32'h0000_0923);
        send(2);
        send(0);
        send(0);
        send(0);
        drain();
        chk("t4_new_coef", 32'(bus.o_x_bn), 32'h0000_0506);

        do_reset();
        busy_len = 20;
        hi_dly   = 0;
        for (int i = 0; i < 8; i++) send(i);
        chk("bp_ready", 32'(bus.o_ready_bn), 0);
        for (int i = 8; i < 12; i++) send(i);
        drain();
        chk("bp_cnt", 32'(bus.o_vec_cnt), 3);
        chk("bp_x", 32'(bus.o_x_bn), 32'h0000_BA98);

        do_reset();
        busy_len = 0;
        for (int i = 1; i <= 4; i++) send(i);
        tick();
        chk("to_start", 32'(bus.o_start_mvm), 1);
        repeat (START_TO) tick();
        chk("to_err_early", 32'(bus.o_err_bn), 0);
        tick();
        chk("to_err", 32'(bus.o_err_bn), 1);
        busy_len = 3;
        hi_dly   = 1;
        for (int i = 5; i <= 8; i++) send(i);
        drain();
        chk("to_sticky", 32'(bus.o_err_bn), 1);
        chk("to_cnt", 32'(bus.o_vec_cnt), 2);

        do_reset();
        busy_len = 20;
        hi_dly   = 0;
        send(9);
        send(9);
        do_reset();
        for (int i = 0; i < 4; i++) send(i * 3);
        tick();
        chk("rs_start", 32'(bus.o_start_mvm), 1);
        repeat (3) tick();
        do_reset();
        repeat (12) tick();
        busy_len = 2;
        hi_dly   = 1;
        send(1);
        send(5);
        send(10);
        send(14);
        drain();
        chk("rs_x", 32'(bus.o_x_bn), 32'h0000_EA51);
        chk("rs_cnt", 32'(bus.o_vec_cnt), 1);

        do_reset();
        for (int i = 0; i < 80; i++) begin
            hi_dly   = int'($urandom_range(0, 3));
            busy_len = int'($urandom_range(1, 6));
            x = $urandom_range(0, 1) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 60)) - 20;
            if ($urandom_range(0, 3) == 0) begin
                n = 0;
                while (!bus.o_ready_bn && n < 200) begin
                    tick();
                    n++;
                end
                l = int'($urandom_range(0, 3));
                g = int'($urandom_range(0, 255)) - 128;
                b = int'($urandom_range(0, 40)) - 20;
                bus.i_cfg_we    = 1'b1;
                bus.i_cfg_lane  = 2'(l);
                bus.i_cfg_gamma = 8'(g);
                bus.i_cfg_beta  = 12'(b);
                send(x);
                bus.i_cfg_we = 1'b0;
                mg[l] = g;
                mb[l] = b;
            end else send(x);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        chk("rnd_err", 32'(bus.o_err_bn), 0);
        chk("rnd_cnt", 32'(bus.o_vec_cnt), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bn_quant.md
Name: bn_quant

Overview:
- Batch-norm/quantise stage directly upstream of the MVM block.
- Accepts a stream of signed accumulator values, one element per cycle.
- Applies a per-lane affine transform, y = gamma*x + beta, then clamps each result to an unsigned 4-bit value.
- Packs four results into a vector, drives it on the MVM i_x_bn input, pulses the MVM start and holds the vector until MVM reports completion through its o_ismvm flag.

Parameters:
- ACC_W, 12, width of signed input accumulator value
- G_W, 8, width of signed gamma coefficient
- FRAC, 4, fractional bits of gamma (Q4.4 by default)
- LANES, 4, elements per output vector (fixed 4 in this revision)
- START_TO, 8, cycles allowed for MVM busy to rise after start

Ports:
- i_clk_bn  in  1  clock
- i_rst_bn  in  1  reset; one clock, asynchronous, active-low
- i_valid_bn  in  1  input element valid
- i_data_bn  in  ACC_W  signed input element
- o_ready_bn  out  1  stage can accept an element this cycle
- i_cfg_we  in  1  coefficient write strobe
- i_cfg_lane  in  2  lane index for write
- i_cfg_gamma  in  G_W  signed gamma for lane
- i_cfg_beta  in  ACC_W  signed beta for lane
- i_ismvm  in  1  MVM busy flag (MVM o_ismvm)
- o_start_mvm  out  1  one-cycle start pulse to MVM
- o_x_bn  out  4 x 4  vector to MVM, lane 0 = first element
- o_vec_cnt  out  16  vectors issued, wraps at 65535->0
- o_err_bn  out  1  sticky: MVM failed to go busy within START_TO

Behaviour:
- Reset (i_rst_bn low, async):
  - all gamma = 1<<FRAC (1.0); all beta = 0
  - collect buffer empty; lane counter 0; FSM IDLE
  - o_x_bn all 0; o_start_mvm 0; o_vec_cnt 0; o_err_bn 0; o_ready_bn 1
- Reset mid-operation aborts any pending vector; no start pulse is emitted afterwards.

- Accept: an element is accepted when i_valid_bn && o_ready_bn.
  - Arithmetic: p = i_data_bn * gamma[lane] (ACC_W+G_W bits, signed).
  - s = (p >>> FRAC) + sign-extended beta. The shift is arithmetic, i.e. floor.
  - Clamp: s<0 -> 0; s>15 -> 15; otherwise s[3:0].
  - Result is written into collect lane [lane counter] at the clock edge; counter then increments.
  - On the 4th accept the counter wraps to 0 and collect_full is set.
- o_ready_bn = !collect_full (combinational). No accepts occur while full.
- Config write:
  - Takes effect from the next cycle.
  - An element accepted in the same cycle as the write uses the old coefficient.
  - Writes are allowed mid-vector.
- Output FSM:
  - IDLE: if collect_full, copy collect buffer to o_x_bn, clear collect_full, go to ISSUE. o_x_bn changes only on this transfer.
  - ISSUE: o_start_mvm = 1 for exactly this cycle; o_vec_cnt increments; go to WAIT_HI; timeout counter cleared.
  - WAIT_HI:
    - if i_ismvm = 1, go to WAIT_LO;
    - else count; when the count reaches START_TO, set o_err_bn and go to IDLE.
  - WAIT_LO: when i_ismvm = 0, go to IDLE. No timeout applies here.
- Latency and throughput:
  - 4th accept at cycle t -> transfer at t+1 -> o_start_mvm high at t+2.
  - o_ready_bn is high again from t+2, so collection of the next vector overlaps the MVM run.
  - A full collect buffer while the FSM is not IDLE holds o_ready_bn low until the transfer.
- i_ismvm already high in ISSUE is ignored; sampling begins in WAIT_HI.
- o_err_bn clears only on reset.

Test Plan:
- Default coefficients; stream 15,15,15,15 -> o_x_bn = {15,15,15,15}; start pulse exactly 2 cycles after the 4th accept; o_vec_cnt = 1.
- Default coefficients; stream -3, 100, 0, 7 -> lanes {0,15,0,7} (clamp low/high, passthrough).
- Lane 0 gamma=24, beta=0, x=5 -> 7 (floor of 7.5).
  - Lane 1 gamma=-32, x=-4 -> 8.
  - Lane 2 gamma=24, beta=10, x=-5 -> 2.
  - Lane 3 gamma=16, beta=-20, x=3 -> 0.
- Backpressure:
  - Hold i_ismvm high for 20 cycles after the first start; stream 12 elements continuously.
  - o_ready_bn drops after the 8th accept.
  - The second start is issued only after i_ismvm falls.
  - Vectors emerge in order; o_vec_cnt = 3 at the end.
- Timeout: i_ismvm held 0 after start -> o_err_bn = 1 exactly START_TO cycles into WAIT_HI; FSM returns to IDLE; the next vector still issues.
- Reset asserted after 2 accepts and again during WAIT_LO -> all outputs return to reset values; no stray start pulse; the next 4 accepts form lane 0..3 cleanly.
